fetch_buffer: RTL and testbench
===============================

FETCH_BUFFER -- requirements
Module: fetch_buffer

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, byte-address width; instruction addresses carry bits [ADDR_WIDTH-1:2].
REQ-002 Parameter DEPTH, default 4, entry count; power of two, DEPTH >= 2.
REQ-003 Port clk  input  1  sole clock; all state changes on posedge clk.
REQ-004 Port rst  input  1  asynchronous, active-high reset.
REQ-005 Port flush  input  1  synchronous discard of all buffered entries (redirect).
REQ-006 Port in_valid  input  1  fetch stage offers an instruction.
REQ-007 Port in_ready  output  1  buffer accepts an instruction this cycle.
REQ-008 Port in_addr  input  ADDR_WIDTH-2  word address of the offered instruction.
REQ-009 Port in_insn  input  32  offered instruction word.
REQ-010 Port out_valid  output  1  decode-side instruction available.
REQ-011 Port out_ready  input  1  decode stage consumes the head entry.
REQ-012 Port out_addr  output  ADDR_WIDTH-2  word address of the head entry.
REQ-013 Port out_insn  output  32  instruction word of the head entry.
REQ-014 Port count  output  $clog2(DEPTH)+1  number of valid entries.
REQ-015 Port err_overflow  output  1  sticky flag: push attempted while full.

Function
REQ-016 Storage SHALL be a DEPTH-entry circular FIFO of {addr, insn}, with read pointer, write pointer and occupancy count registers.
REQ-017 Push SHALL occur when in_valid && in_ready && !flush; the entry is written at the write pointer, which then advances.
REQ-018 Pop SHALL occur when out_valid && out_ready && !flush; the read pointer then advances.
REQ-019 in_ready SHALL equal (count != DEPTH), derived from registered state only, with no combinational path from out_ready.
REQ-020 out_valid SHALL equal (count != 0); out_addr/out_insn SHALL show the head entry whenever out_valid is high (first-word-fall-through).
REQ-021 Latency: an instruction pushed in cycle N SHALL be visible on out_* in cycle N+1 at the earliest; no same-cycle bypass.
REQ-022 Simultaneous push and pop SHALL leave count unchanged and move both pointers; this is legal whenever 0 < count < DEPTH.
REQ-023 A push and a pop in the same cycle with count==0 SHALL NOT occur, because out_valid is low; only the push takes effect.
REQ-024 When full (count==DEPTH), in_ready SHALL be low; a same-cycle pop does not raise in_ready until the next cycle.
REQ-025 Pointers SHALL wrap modulo DEPTH; FIFO order SHALL be preserved across wrap.
REQ-026 While out_valid is high and out_ready is low, out_addr/out_insn SHALL hold stable.
REQ-027 flush SHALL set count, rptr and wptr to 0 on the next edge; any push or pop in the flush cycle is ignored.
REQ-028 flush SHALL clear err_overflow.
REQ-029 err_overflow SHALL set on any cycle with in_valid && !in_ready && !flush, and hold until flush or rst.
REQ-030 Storage array contents SHALL NOT need reset; only pointers, count and err_overflow are reset.
REQ-031 count SHALL never exceed DEPTH nor underflow below 0 under any input sequence.

Reset
REQ-032 While rst is high, count=0, pointers=0 and err_overflow=0; hence out_valid=0 and in_ready=1, asynchronously.
REQ-033 rst asserted mid-operation SHALL discard all entries immediately; after deassertion the first push SHALL appear on out_* one cycle later.
REQ-034 No push or pop SHALL take effect on a clock edge while rst is high.

Verification
REQ-035 Fill and drain, out_ready=0: push addrs 0x100..0x103 with insns 0xA0..0xA3 -> count 1,2,3,4; in_ready=0 after the 4th; then out_ready=1 -> pops 0x100..0x103 in order, count back to 0.
REQ-036 Streaming, in_valid=out_ready=1 for 20 cycles with incrementing addr -> after 1 cycle of latency one pop per cycle, count steady at 1, order preserved across multiple pointer wraps.
REQ-037 Full plus pop: count=4, in_valid=1, out_ready=1 -> the pop occurs and the push is refused (err_overflow=1); next cycle count=3 and in_ready=1.
REQ-038 Flush: count=3 with flush=1 and in_valid=1 in the same cycle -> next cycle count=0, out_valid=0, err_overflow=0, and the pushed entry is absent.
REQ-039 Async reset mid-stream: rst pulsed between edges with count=2 -> out_valid drops immediately without a clock edge; after release, push 0x200 -> out_addr=0x200 next cycle.
REQ-040 Backpressure hold: out_valid=1, out_ready=0 for 5 cycles while in_valid toggles -> out_addr/out_insn unchanged for all 5 cycles.

Source files
------------

// File: rtl/fetch_buffer.sv
// fetch_buffer: DEPTH-entry first-word-fall-through FIFO of {word address,
// instruction} pairs sitting between the fetch and decode stages. Handshakes
// are derived from registered occupancy only, so in_ready never depends
// combinationally on out_ready. A flush (redirect) discards every entry.
module fetch_buffer #(
  parameter int ADDR_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [ADDR_WIDTH-3:0]      in_addr,
  input  logic [31:0]                in_insn,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [ADDR_WIDTH-3:0]      out_addr,
  output logic [31:0]                out_insn,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       err_overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int AW    = ADDR_WIDTH - 2;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  // Entry storage; contents are meaningless until written, so no reset.
  logic [AW-1:0] addr_mem [DEPTH];
  logic [31:0]   insn_mem [DEPTH];

  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             err_q, err_d;

  logic push;
  logic pop;

  // Handshakes come from registered occupancy only.
  assign in_ready  = (count_q != FULL_CNT);
  assign out_valid = (count_q != '0);

  // A flush cycle ignores both sides of the handshake.
  assign push = in_valid  & in_ready  & ~flush;
  assign pop  = out_valid & out_ready & ~flush;

  // Head entry is presented straight from storage (fall-through).
  assign out_addr     = addr_mem[rptr_q];
  assign out_insn     = insn_mem[rptr_q];
  assign count        = count_q;
  assign err_overflow = err_q;

  // Write the offered entry at the write pointer on every accepted push.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wptr_q] <= in_addr;
      insn_mem[wptr_q] <= in_insn;
    end
  end

  // Next-state for pointers, occupancy and the sticky overflow flag.
  always_comb begin
    rptr_d  = rptr_q;
    wptr_d  = wptr_q;
    count_d = count_q;
    err_d   = err_q;
    if (flush) begin
      rptr_d  = '0;
      wptr_d  = '0;
      count_d = '0;
      err_d   = 1'b0;
    end else begin
      // Pointers wrap naturally because DEPTH is a power of two.
      if (push) wptr_d = wptr_q + PTR_W'(1);
      if (pop)  rptr_d = rptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
      if (in_valid && !in_ready) err_d = 1'b1;
    end
  end

  // Control state register; reset clears it without waiting for a clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rptr_q  <= '0;
      wptr_q  <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      rptr_q  <= rptr_d;
      wptr_q  <= wptr_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_fetch_buffer.sv
// tb_fetch_buffer: directed vectors for fetch_buffer (DEPTH=4) with
// hand-computed expected values; one line printed per comparison.
module tb_fetch_buffer;

  localparam int ADDR_WIDTH = 32;
  localparam int DEPTH      = 4;
  localparam int AW         = ADDR_WIDTH - 2;

  logic          clk;
  logic          rst;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [AW-1:0] in_addr;
  logic [31:0]   in_insn;
  logic          out_valid;
  logic          out_ready;
  logic [AW-1:0] out_addr;
  logic [31:0]   out_insn;
  logic [2:0]    count;
  logic          err_overflow;

  int n_checks = 0;
  int n_fail   = 0;

  fetch_buffer #(.ADDR_WIDTH(ADDR_WIDTH), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_addr      (in_addr),
    .in_insn      (in_insn),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_addr     (out_addr),
    .out_insn     (out_insn),
    .count        (count),
    .err_overflow (err_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, obs);
    end
  endtask

  // Advance one clock edge; outputs are sampled 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst       = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_addr   = '0;
    in_insn   = '0;
    out_ready = 1'b0;

    // Reset state, no clock edge yet.
    #2;
    check("rst_count",     64'(count), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready",  64'(in_ready), 64'd1);
    check("rst_err",       64'(err_overflow), 64'd0);
    step();
    rst = 1'b0;
    step();

    // Fill with decode stalled.
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_addr  = AW'(32'h100 + i);
      in_insn  = 32'hA0 + i;
      step();
      check($sformatf("fill_count%0d", i), 64'(count), 64'(i + 1));
    end
    in_valid = 1'b0;
    check("fill_in_ready", 64'(in_ready), 64'd0);
    check("fill_head",     64'(out_addr), 64'h100);
    check("fill_err",      64'(err_overflow), 64'd0);

    // Drain in order.
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("drain_addr%0d", i), 64'(out_addr), 64'(32'h100 + i));
      check($sformatf("drain_insn%0d", i), 64'(out_insn), 64'(32'hA0 + i));
      step();
      check($sformatf("drain_count%0d", i), 64'(count), 64'(3 - i));
    end
    out_ready = 1'b0;
    check("drain_out_valid", 64'(out_valid), 64'd0);

    // Full plus pop: pop happens, push is refused and flagged.
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_addr  = AW'(32'h110 + i);
      in_insn  = 32'hB0 + i;
      step();
    end
    check("full_count", 64'(count), 64'd4);
    in_addr   = AW'(32'h1FF);
    in_insn   = 32'hBFF;
    out_ready = 1'b1;
    check("full_in_ready_pre", 64'(in_ready), 64'd0);
    step();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("fullpop_count",    64'(count), 64'd3);
    check("fullpop_in_ready", 64'(in_ready), 64'd1);
    check("fullpop_err",      64'(err_overflow), 64'd1);
    check("fullpop_head",     64'(out_addr), 64'h111);

    // Flush with a simultaneous push.
    flush    = 1'b1;
    in_valid = 1'b1;
    in_addr  = AW'(32'h1EE);
    in_insn  = 32'hEE;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    check("flush_count",     64'(count), 64'd0);
    check("flush_out_valid", 64'(out_valid), 64'd0);
    check("flush_err",       64'(err_overflow), 64'd0);
    step();
    check("flush_absent",    64'(out_valid), 64'd0);

    // Streaming across several pointer wraps.
    out_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      in_valid = 1'b1;
      in_addr  = AW'(32'h300 + k);
      in_insn  = 32'hC000 + k;
      step();
      check($sformatf("stream_count%0d", k), 64'(count), 64'd1);
      check($sformatf("stream_addr%0d", k),  64'(out_addr), 64'(32'h300 + k));
      check($sformatf("stream_insn%0d", k),  64'(out_insn), 64'(32'hC000 + k));
    end
    in_valid = 1'b0;
    step();
    out_ready = 1'b0;
    check("stream_end_count", 64'(count), 64'd0);

    // Backpressure hold while in_valid toggles.
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      in_addr  = AW'(32'h400 + i);
      in_insn  = 32'hD00 + i;
      step();
    end
    for (int c = 0; c < 5; c++) begin
      in_valid = (c % 2 == 0);
      in_addr  = AW'(32'h410 + c);
      in_insn  = 32'hD10 + c;
      step();
      check($sformatf("hold_addr%0d", c), 64'(out_addr), 64'h400);
      check($sformatf("hold_insn%0d", c), 64'(out_insn), 64'hD00);
    end
    in_valid = 1'b0;
    check("hold_count", 64'(count), 64'd4);
    check("hold_err",   64'(err_overflow), 64'd1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("hold_flush_err", 64'(err_overflow), 64'd0);

    // Asynchronous reset mid-stream.
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      in_addr  = AW'(32'h500 + i);
      in_insn  = 32'hE00 + i;
      step();
    end
    in_valid = 1'b0;
    check("arst_pre_count", 64'(count), 64'd2);
    #2;
    rst = 1'b1;
    #1;
    check("arst_out_valid", 64'(out_valid), 64'd0);
    check("arst_count",     64'(count), 64'd0);
    check("arst_in_ready",  64'(in_ready), 64'd1);
    in_valid  = 1'b1;
    in_addr   = AW'(32'h5AA);
    in_insn   = 32'hEAA;
    out_ready = 1'b1;
    step();
    check("arst_hold_count", 64'(count), 64'd0);
    #2;
    rst     = 1'b0;
    in_addr = AW'(32'h200);
    in_insn = 32'hEEE;
    step();
    in_valid = 1'b0;
    check("arst_push_valid", 64'(out_valid), 64'd1);
    check("arst_push_addr",  64'(out_addr), 64'h200);
    check("arst_push_insn",  64'(out_insn), 64'hEEE);
    check("arst_push_count", 64'(count), 64'd1);
    step();
    check("arst_pop_count",  64'(count), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
